// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single start/ready memory port.
// Requester A is instruction fetch, B is data; one transaction in flight, with a timeout watchdog.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_rwn,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_done,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_rwn,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_done,
  output logic          b_err,
  output logic          mem_start,
  output logic          mem_rwn,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  state_t         state_q, state_d;
  logic           grant_q, grant_d;   // 1 = B
  logic           last_q, last_d;     // last requester served, 1 = B
  logic           hold_q, hold_d;     // grant decided but memory not yet ready
  logic           err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           rwn_q, rwn_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [DW-1:0]  a_rdata_q, a_rdata_d;
  logic [DW-1:0]  b_rdata_q, b_rdata_d;
  logic           pick_b;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    hold_d    = hold_q;
    err_d     = err_q;
    wd_d      = wd_q;
    rwn_d     = rwn_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    pick_b    = 1'b0;

    case (state_q)
      IDLE: begin
        // A held decision survives req changes while the memory is still busy.
        if (hold_q)              pick_b = grant_q;
        else if (a_req && b_req) pick_b = ~last_q;
        else                     pick_b = b_req;

        if (hold_q || a_req || b_req) begin
          grant_d = pick_b;
          if (mem_ready) begin
            hold_d  = 1'b0;
            err_d   = 1'b0;
            wd_d    = '0;
            rwn_d   = pick_b ? b_rwn   : a_rwn;
            addr_d  = pick_b ? b_addr  : a_addr;
            wdata_d = pick_b ? b_wdata : a_wdata;
            state_d = ISSUE;
          end else begin
            hold_d  = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        wd_d = wd_q + WDW'(1);
        if (mem_ready) begin
          if (rwn_q) begin
            if (grant_q) b_rdata_d = mem_data_out;
            else         a_rdata_d = mem_data_out;
          end
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = grant_q;
        wd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
      rwn_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
      rwn_q     <= rwn_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign mem_start   = (state_q == ISSUE);
  assign mem_rwn     = rwn_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign a_done      = (state_q == DONE) && !grant_q;
  assign b_done      = (state_q == DONE) &&  grant_q;
  assign a_err       = a_done && err_q;
  assign b_err       = b_done && err_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-addressed memory model
// whose wait is 1 + addr[1:0] cycles after start and which can be forced not-ready.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_req = 1'b0, a_rwn = 1'b1;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata;
  logic        a_done, a_err;
  logic        b_req = 1'b0, b_rwn = 1'b1;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [31:0] b_rdata;
  logic        b_done, b_err;
  logic        mem_start, mem_rwn;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_rwn(a_rwn), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_done(a_done), .a_err(a_err),
    .b_req(b_req), .b_rwn(b_rwn), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_done(b_done), .b_err(b_err),
    .mem_start(mem_start), .mem_rwn(mem_rwn), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  // Memory model
  logic [7:0]  mem [256];
  int          busy = 0;
  logic        stuck = 1'b0;
  logic [31:0] rd_q = '0;
  logic [7:0]  ma0, ma1, ma2, ma3;
  assign ma0 = mem_address[7:0];
  assign ma1 = ma0 + 8'd1;
  assign ma2 = ma0 + 8'd2;
  assign ma3 = ma0 + 8'd3;
  assign mem_ready    = (busy == 0) && !stuck;
  assign mem_data_out = rd_q;

  always @(posedge clk) begin
    if (!reset) begin
      busy <= 0;
      rd_q <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[0]     <= 8'hC4;
      mem[1]     <= 8'h15;
      mem[3]     <= 8'h01;
      mem[8'h40] <= 8'h14;
      mem[8'h84] <= 8'h0A;
    end else if (mem_start) begin
      busy <= 1 + int'(mem_address[1:0]);
      if (mem_rwn) begin
        rd_q <= {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
      end else begin
        mem[ma0] <= mem_data_in[7:0];
        mem[ma1] <= mem_data_in[15:8];
        mem[ma2] <= mem_data_in[23:16];
        mem[ma3] <= mem_data_in[31:24];
      end
    end else if (busy > 0) begin
      busy <= busy - 1;
    end
  end

  typedef struct {
    logic        is_b;
    logic        rwn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {58'd0, a_done, a_err, b_done, b_err, mem_start, mem_rwn}, 64'd0);
    check({tag, "_addr"}, {32'd0, mem_address}, 64'd0);
    check({tag, "_wdata"}, {32'd0, mem_data_in}, 64'd0);
    check({tag, "_a_rdata"}, {32'd0, a_rdata}, 64'd0);
    check({tag, "_b_rdata"}, {32'd0, b_rdata}, 64'd0);
  endtask

  // Single-requester transaction; entered and left on a negedge with the DUT in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int n = 0, starts = 0, done_at = -1, other = 0;
    logic err = 1'b0, cap_rwn = 1'bx;
    logic [31:0] cap_addr = 'x, cap_wd = 'x, rd = 'x;
    string p;
    p = $sformatf("vec%0d", idx);
    if (v.is_b) begin
      b_req = 1'b1; b_rwn = v.rwn; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_rwn = v.rwn; a_addr = v.addr; a_wdata = v.wdata;
    end
    while (done_at < 0 && n < 60) begin
      @(posedge clk); n++; @(negedge clk);
      if (mem_start) begin
        starts++; cap_rwn = mem_rwn; cap_addr = mem_address; cap_wd = mem_data_in;
      end
      if (v.is_b ? b_done : a_done) begin
        done_at = n; err = v.is_b ? b_err : a_err; rd = v.is_b ? b_rdata : a_rdata;
      end
      if (v.is_b ? a_done : b_done) other++;
    end
    a_req = 1'b0; b_req = 1'b0;
    check({p, "_latency"}, done_at, v.lat);
    check({p, "_starts"}, starts, 1);
    check({p, "_mem_rwn"}, cap_rwn, v.rwn);
    check({p, "_mem_addr"}, cap_addr, v.addr);
    check({p, "_mem_wdata"}, cap_wd, v.wdata);
    check({p, "_rdata"}, rd, v.exp_rd);
    check({p, "_err"}, err, 1'b0);
    check({p, "_other_done"}, other, 0);
    @(negedge clk);
  endtask

  task automatic seq_round_robin();
    int n = 0, k = 0, starts = 0;
    int dt [4] = '{0, 0, 0, 0};
    logic wb [4] = '{1'bx, 1'bx, 1'bx, 1'bx};
    a_req = 1'b1; a_rwn = 1'b1; a_addr = 32'h0;
    b_req = 1'b1; b_rwn = 1'b1; b_addr = 32'h0;
    while (k < 4 && n < 60) begin
      @(posedge clk); n++; @(negedge clk);
      if (mem_start) starts++;
      if (a_done || b_done) begin
        dt[k] = n; wb[k] = b_done; k++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("rr_done_count", k, 4);
    check("rr_start_count", starts, 4);
    check("rr_first_latency", dt[0], 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_grant%0d_is_b", i), wb[i], (i % 2 == 1));
      if (i > 0) check($sformatf("rr_spacing%0d", i), dt[i] - dt[i-1], 5);
    end
    check("rr_a_rdata", a_rdata, 32'h010015C4);
    check("rr_b_rdata", b_rdata, 32'h010015C4);
    @(negedge clk);
  endtask

  task automatic seq_timeout();
    int n = 0, done_n = -1, starts = 0, first_done = -1;
    logic err = 1'b0, first_b = 1'bx;
    logic [31:0] cap_addr = 'x;
    a_req = 1'b1; a_rwn = 1'b1; a_addr = 32'h0;
    while (done_n < 0 && n < 60) begin
      @(posedge clk); n++; @(negedge clk);
      if (mem_start) stuck = 1'b1;
      if (a_done) begin done_n = n; err = a_err; end
    end
    a_req = 1'b0;
    check("to_latency", done_n, 18);
    check("to_err", err, 1'b1);
    check("to_rdata_kept", a_rdata, 32'h010015C4);
    @(negedge clk);
    // Memory still not ready: A is decided first, then B joins; A must keep the grant.
    a_req = 1'b1; a_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    if (mem_start) starts++;
    b_req = 1'b1; b_rwn = 1'b1; b_addr = 32'h3;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (mem_start) starts++;
    end
    check("to_stall_no_start", starts, 0);
    stuck = 1'b0;
    n = 0;
    while (first_done < 0 && n < 60) begin
      @(posedge clk); n++; @(negedge clk);
      if (mem_start) cap_addr = mem_address;
      if (a_done || b_done) begin first_done = n; first_b = b_done; end
    end
    a_req = 1'b0; b_req = 1'b0;
    check("to_held_grant_addr", cap_addr, 32'h40);
    check("to_held_grant_is_b", first_b, 1'b0);
    check("to_recover_latency", first_done, 4);
    check("to_recover_rdata", a_rdata, 32'h00000014);
    @(negedge clk);
  endtask

  task automatic seq_reset();
    int n = 0, a_done_n = -1, b_done_n = -1, early_b = 0;
    logic [31:0] first_addr = 'x;
    logic seen_start = 1'b0;
    b_req = 1'b1; b_rwn = 1'b1; b_addr = 32'h3;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    a_req = 1'b1; a_rwn = 1'b1; a_addr = 32'h40;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) begin
      @(negedge clk);
      if (b_done) early_b++;
    end
    reset = 1'b1;
    while (b_done_n < 0 && n < 60) begin
      @(posedge clk); n++; @(negedge clk);
      if (mem_start && !seen_start) begin seen_start = 1'b1; first_addr = mem_address; end
      if (a_done) begin a_done_n = n; a_req = 1'b0; end
      if (b_done) begin
        b_done_n = n;
        if (a_done_n < 0) early_b++;
      end
    end
    b_req = 1'b0;
    check("rst_no_early_b_done", early_b, 0);
    check("rst_first_grant_addr", first_addr, 32'h40);
    check("rst_a_latency", a_done_n, 4);
    check("rst_a_rdata", a_rdata, 32'h00000014);
    check("rst_b_done_cycle", b_done_n, 12);
    check("rst_b_rdata", b_rdata, 32'h00000001);
    @(negedge clk);
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b1, 32'h00, 32'h0,        4, 32'h010015C4};
    vt[1] = '{1'b1, 1'b1, 32'h40, 32'h0,        4, 32'h00000014};
    vt[2] = '{1'b1, 1'b1, 32'h83, 32'h0,        7, 32'h00000A00};
    vt[3] = '{1'b1, 1'b0, 32'hF0, 32'hDEADBEEF, 4, 32'h00000A00};
    vt[4] = '{1'b0, 1'b1, 32'hF0, 32'h0,        4, 32'hDEADBEEF};
    vt[5] = '{1'b0, 1'b1, 32'h02, 32'h0,        6, 32'h00000100};
    vt[6] = '{1'b0, 1'b1, 32'hFE, 32'h0,        6, 32'h15C40000};
    vt[7] = '{1'b1, 1'b0, 32'h11, 32'h12345678, 5, 32'h00000A00};
    vt[8] = '{1'b0, 1'b1, 32'h11, 32'h0,        5, 32'h12345678};
    vt[9] = '{1'b1, 1'b1, 32'h11, 32'h0,        5, 32'h12345678};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_init");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vt[i]);
    seq_round_robin();
    seq_timeout();
    seq_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: got no finish expected finish before 100000");
    $fatal(1, "time limit");
  end

endmodule
